sine_lut_phase_gen: RTL and testbench
=====================================

Name: sine_lut_phase_gen

Overview:
- Initiator side of the three-port sine LUT read interface.
- Runs a phase accumulator from a frequency control word (FCW) and drives three registered LUT addresses at 0°, 120° and 240°.
- Captures the three LUT data words after the fixed 1-cycle LUT latency and presents an aligned three-phase sample set with a valid strobe.
- Sits between the control/tuning logic and the LUT ROM in the three-phase sine generator.

Parameters:
- ACC_W, 32: phase accumulator width.
- ADDR_W, 15: LUT address width; address = accumulator MSBs.
- DATA_W, 16: LUT data and sample width; samples are signed.
- LUT_LAT, 1: LUT read latency in clocks (registered read).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; high = generate, low = stop.
- fcw_in  in  ACC_W  requested frequency control word.
- fcw_valid  in  1  fcw_in is valid.
- fcw_ready  out  1  block can accept a new FCW.
- address1 / address2 / address3  out  ADDR_W each  LUT addresses for 0°, 120° and 240°.
- data1 / data2 / data3  in  DATA_W each  LUT read data, valid LUT_LAT cycles after the address.
- sample1 / sample2 / sample3  out  DATA_W each  captured three-phase samples.
- sample_valid  out  1  sample1..3 updated this cycle.

Behaviour:
- Reset (async, immediate):
  - acc = 0, fcw_cur = 0, fcw_pend = 0, pend_flag = 0.
  - address1..3 = 0, sample1..3 = 0, sample_valid = 0, fcw_ready = 1, state = IDLE.
  - The valid pipeline is cleared. Reset asserted mid-RUN aborts at once; no samples are flushed.
- Phase offsets, in accumulator units:
  - PH120 = ceil(2^ACC_W / 3); PH240 = 2*PH120 mod 2^ACC_W.
  - Defaults: 0x55555556 and 0xAAAAAAAC.
  - address1 = acc[ACC_W-1 -: ADDR_W]; address2 and address3 are the top ADDR_W bits of (acc + PH120) and (acc + PH240), modulo 2^ACC_W.
  - At acc = 0 (defaults): 0, 10922, 21845.
- Accumulator:
  - In RUN: acc <= acc + fcw_cur each cycle, mod 2^ACC_W, wrapping silently.
  - Addresses are registered from the current acc on the same edge.
- State machine IDLE -> RUN -> DRAIN -> IDLE:
  - IDLE: acc held at 0, no address issue. run = 1 moves to RUN on the next edge.
  - RUN: one address triple issued per cycle, and addr_issue is shifted into a valid pipe of depth LUT_LAT+1. run = 0 moves to DRAIN.
  - DRAIN: no new issue; addresses hold their last value. Stay LUT_LAT+1 cycles so in-flight samples emerge, then go to IDLE and clear acc to 0.
  - run reasserted during DRAIN is ignored until IDLE is reached; the restart begins at phase 0.
- Latency:
  - Address registered at edge k, LUT data valid after edge k+1, samples registered at edge k+2 with sample_valid = 1.
  - Issue-to-sample latency is 2 cycles (LUT_LAT+1).
  - sample_valid stays high every cycle in steady RUN.
- FCW handshake (valid/ready, transfer when both high):
  - In IDLE: the transfer loads fcw_cur directly; fcw_ready stays 1.
  - In RUN/DRAIN: the transfer loads fcw_pend, sets pend_flag and drops fcw_ready.
  - The pending FCW is applied on the first cycle where acc + fcw_cur overflows 2^ACC_W (phase wrap). That step still uses the old FCW; the new one is used from the next step on.
  - pend_flag then clears and fcw_ready returns to 1 on the following cycle.
- Boundaries:
  - fcw_cur = 0 in RUN: addresses constant; samples still valid every cycle.
  - Pending FCW still outstanding when IDLE is entered: it is applied to fcw_cur on entry.
  - fcw_valid while fcw_ready = 0: no transfer; the requester must hold its value.
- sample1..3 hold their last value when sample_valid = 0.

Optional Feature:
- Macro: SINE_AMP_SCALE_EN.
- When defined:
  - Adds input amp (16 bits, unsigned Q1.15; 0x8000 = unity, maximum).
  - Adds one multiply stage: sampleN = (dataN * amp) >>> 15, signed arithmetic, truncated to DATA_W.
  - Issue-to-sample latency becomes 3 cycles, and DRAIN lasts LUT_LAT+2 cycles.
  - amp is sampled in the multiply stage each cycle (no handshake).
- When undefined: no amp port; samples are the raw LUT data at 2-cycle latency.

Test Plan:
- Reset, load fcw = 0x00020000 in IDLE, raise run -> address1 steps 0,1,2,... per cycle with address2 = address1+10922 and address3 = address1+21845 (mod 32768); first sample_valid 2 cycles after the first issue, and sample1..3 equal the LUT model at those addresses.
- Drop run after 10 issues -> exactly 10 sample_valid pulses total, then IDLE; acc = 0 and address1..3 = 0 on the next restart.
- During RUN with fcw = 0x40000000, offer fcw = 0x00020000 at acc = 0x40000000 -> fcw_ready low, acc steps 0x80000000, 0xC0000000, 0x00000000 (wrap), then increments by 0x00020000; fcw_ready returns high 1 cycle after the wrap.
- Assert rst for 1 cycle mid-RUN -> all outputs 0 immediately, sample_valid 0, state IDLE, no stale sample_valid afterwards.
- fcw = 0 in RUN -> addresses fixed at 0/10922/21845; sample_valid continuously 1.
- With SINE_AMP_SCALE_EN and amp = 0x4000 -> samples equal half the LUT value (arithmetic shift) at 3-cycle latency; amp = 0x8000 -> samples equal the raw LUT value.

Source files
------------

// File: rtl/sine_lut_phase_gen_if.sv
// Bus bundle between the three-phase phase generator, its FCW requester,
// the three-port sine LUT and the sample consumer.
// With SINE_AMP_SCALE_EN defined the bundle also carries the amplitude word.
interface sine_lut_phase_gen_if #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);

  logic              run;
  logic [ACC_W-1:0]  fcw_in;
  logic              fcw_valid;
  logic              fcw_ready;
  logic [ADDR_W-1:0] address1;
  logic [ADDR_W-1:0] address2;
  logic [ADDR_W-1:0] address3;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic [DATA_W-1:0] sample1;
  logic [DATA_W-1:0] sample2;
  logic [DATA_W-1:0] sample3;
  logic              sample_valid;
`ifdef SINE_AMP_SCALE_EN
  logic [15:0]       amp;
`endif

`ifdef SINE_AMP_SCALE_EN
  // Generator side
  modport master (
    input  run, fcw_in, fcw_valid, data1, data2, data3, amp,
    output fcw_ready, address1, address2, address3,
           sample1, sample2, sample3, sample_valid
  );

  // Environment side (requester, LUT, consumer)
  modport slave (
    output run, fcw_in, fcw_valid, data1, data2, data3, amp,
    input  fcw_ready, address1, address2, address3,
           sample1, sample2, sample3, sample_valid
  );
`else
  // Generator side
  modport master (
    input  run, fcw_in, fcw_valid, data1, data2, data3,
    output fcw_ready, address1, address2, address3,
           sample1, sample2, sample3, sample_valid
  );

  // Environment side (requester, LUT, consumer)
  modport slave (
    output run, fcw_in, fcw_valid, data1, data2, data3,
    input  fcw_ready, address1, address2, address3,
           sample1, sample2, sample3, sample_valid
  );
`endif

endinterface

// File: rtl/sine_lut_phase_gen.sv
// Three-phase sine LUT initiator: phase accumulator driven by an FCW, three
// registered LUT addresses at 0/120/240 degrees, and an aligned sample set
// captured after the LUT read latency.
// Optional macro SINE_AMP_SCALE_EN: adds a Q1.15 amplitude multiply stage
// (one extra cycle of latency and one extra drain cycle).
module sine_lut_phase_gen #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LUT_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sine_lut_phase_gen_if.master  bus
);

  // ceil(2^ACC_W / 3) == floor((2^ACC_W - 1) / 3) + 1, since 3 never divides 2^ACC_W
  localparam logic [ACC_W-1:0] L_PH120 = ACC_W'({ACC_W{1'b1}} / ACC_W'(3)) + ACC_W'(1);
  localparam logic [ACC_W-1:0] L_PH240 = ACC_W'(L_PH120 + L_PH120);
  localparam int unsigned      L_SHIFT = ACC_W - ADDR_W;
  localparam int unsigned      L_VPIPE = LUT_LAT + 1;
`ifdef SINE_AMP_SCALE_EN
  localparam int unsigned      L_DRAIN  = LUT_LAT + 2;
  localparam int unsigned      L_AMP_W  = 16;
  localparam int unsigned      L_PROD_W = DATA_W + L_AMP_W + 1;
  localparam int unsigned      L_FRAC   = 15;
`else
  localparam int unsigned      L_DRAIN  = LUT_LAT + 1;
`endif
  localparam int unsigned      L_CNT_W = (L_DRAIN > 1) ? $clog2(L_DRAIN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_fcw_cur;
  logic [ACC_W-1:0]    r_fcw_pend;
  logic                r_pend_flag;
  logic                r_fcw_ready;
  logic [L_CNT_W-1:0]  r_drain_cnt;
  logic [ADDR_W-1:0]   r_address1;
  logic [ADDR_W-1:0]   r_address2;
  logic [ADDR_W-1:0]   r_address3;
  logic [L_VPIPE-1:0]  r_vpipe;
  logic [DATA_W-1:0]   r_sample1;
  logic [DATA_W-1:0]   r_sample2;
  logic [DATA_W-1:0]   r_sample3;
  logic                r_sample_valid;

  logic [ACC_W:0]      w_sum;
  logic                w_wrap;
  logic                w_xfer;
  logic                w_issue;
  logic                w_lut_valid;
  logic [ADDR_W-1:0]   w_addr1;
  logic [ADDR_W-1:0]   w_addr2;
  logic [ADDR_W-1:0]   w_addr3;

  // Accumulator step with carry-out marking the phase wrap
  assign w_sum       = {1'b0, r_acc} + {1'b0, r_fcw_cur};
  assign w_wrap      = w_sum[ACC_W];
  assign w_xfer      = bus.fcw_valid & r_fcw_ready;
  assign w_issue     = (r_state == S_RUN);
  assign w_lut_valid = r_vpipe[L_VPIPE-1];

  // Addresses for the three phases taken from the current accumulator
  assign w_addr1 = r_acc[ACC_W-1 -: ADDR_W];
  assign w_addr2 = ADDR_W'((r_acc + L_PH120) >> L_SHIFT);
  assign w_addr3 = ADDR_W'((r_acc + L_PH240) >> L_SHIFT);

  // Control FSM: accumulator, FCW handshake, address issue and drain timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_fcw_cur   <= '0;
      r_fcw_pend  <= '0;
      r_pend_flag <= 1'b0;
      r_fcw_ready <= 1'b1;
      r_drain_cnt <= '0;
      r_address1  <= '0;
      r_address2  <= '0;
      r_address3  <= '0;
    end else begin
      // Ready drops on a buffered transfer and returns once nothing is pending
      if (w_xfer && (r_state != S_IDLE)) begin
        r_fcw_ready <= 1'b0;
      end else if (!r_pend_flag) begin
        r_fcw_ready <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_acc <= '0;
          if (w_xfer) begin
            r_fcw_cur <= bus.fcw_in;
          end
          if (bus.run) begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_address1 <= w_addr1;
          r_address2 <= w_addr2;
          r_address3 <= w_addr3;
          r_acc      <= w_sum[ACC_W-1:0];
          // The wrapping step still uses the old FCW
          if (r_pend_flag && w_wrap) begin
            r_fcw_cur   <= r_fcw_pend;
            r_pend_flag <= 1'b0;
          end
          if (w_xfer) begin
            r_fcw_pend  <= bus.fcw_in;
            r_pend_flag <= 1'b1;
          end
          if (!bus.run) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
          end
        end

        S_DRAIN: begin
          if (w_xfer) begin
            r_fcw_pend  <= bus.fcw_in;
            r_pend_flag <= 1'b1;
          end
          if (r_drain_cnt == L_CNT_W'(L_DRAIN - 1)) begin
            // Leaving for IDLE: restart from phase 0, apply any outstanding FCW
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_pend_flag <= 1'b0;
            if (w_xfer) begin
              r_fcw_cur <= bus.fcw_in;
            end else if (r_pend_flag) begin
              r_fcw_cur <= r_fcw_pend;
            end
          end else begin
            r_drain_cnt <= r_drain_cnt + L_CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Issue tracking pipe: the last stage marks LUT data that belongs to an issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe <= L_VPIPE'({r_vpipe, w_issue});
    end
  end

`ifdef SINE_AMP_SCALE_EN
  logic                       r_mul_valid;
  logic signed [L_PROD_W-1:0] r_prod1;
  logic signed [L_PROD_W-1:0] r_prod2;
  logic signed [L_PROD_W-1:0] r_prod3;
  logic signed [L_PROD_W-1:0] w_prod1;
  logic signed [L_PROD_W-1:0] w_prod2;
  logic signed [L_PROD_W-1:0] w_prod3;

  // amp is unsigned Q1.15, so it is zero-extended before the signed multiply
  assign w_prod1 = $signed(bus.data1) * $signed({1'b0, bus.amp});
  assign w_prod2 = $signed(bus.data2) * $signed({1'b0, bus.amp});
  assign w_prod3 = $signed(bus.data3) * $signed({1'b0, bus.amp});

  // Multiply stage followed by the Q1.15 rescale into the sample registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_valid    <= 1'b0;
      r_prod1        <= '0;
      r_prod2        <= '0;
      r_prod3        <= '0;
      r_sample1      <= '0;
      r_sample2      <= '0;
      r_sample3      <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_mul_valid    <= w_lut_valid;
      r_sample_valid <= r_mul_valid;
      if (w_lut_valid) begin
        r_prod1 <= w_prod1;
        r_prod2 <= w_prod2;
        r_prod3 <= w_prod3;
      end
      if (r_mul_valid) begin
        r_sample1 <= DATA_W'(r_prod1 >>> L_FRAC);
        r_sample2 <= DATA_W'(r_prod2 >>> L_FRAC);
        r_sample3 <= DATA_W'(r_prod3 >>> L_FRAC);
      end
    end
  end
`else
  // Capture raw LUT data for issued addresses; hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample1      <= '0;
      r_sample2      <= '0;
      r_sample3      <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_lut_valid;
      if (w_lut_valid) begin
        r_sample1 <= bus.data1;
        r_sample2 <= bus.data2;
        r_sample3 <= bus.data3;
      end
    end
  end
`endif

  assign bus.fcw_ready    = r_fcw_ready;
  assign bus.address1     = r_address1;
  assign bus.address2     = r_address2;
  assign bus.address3     = r_address3;
  assign bus.sample1      = r_sample1;
  assign bus.sample2      = r_sample2;
  assign bus.sample3      = r_sample3;
  assign bus.sample_valid = r_sample_valid;

endmodule

// File: tb/tb_sine_lut_phase_gen.sv
// Bench for sine_lut_phase_gen: registered LUT model, directed scenarios and
// randomized bursts checked against an issue/latency reference model.
module tb_sine_lut_phase_gen;

`ifdef SINE_AMP_SCALE_EN
  localparam int L_LAT = 3;
`else
  localparam int L_LAT = 2;
`endif
  localparam logic [31:0] PH120 = 32'(((64'd1 << 32) + 64'd2) / 64'd3);
  localparam logic [31:0] PH240 = 32'(64'(PH120) * 64'd2);

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  sine_lut_phase_gen_if bus ();

  sine_lut_phase_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Arbitrary deterministic ROM contents
  function automatic logic [15:0] lut(input logic [14:0] a);
    logic [31:0] t;
    t = {17'd0, a} * 32'd40503 + 32'h1357;
    return t[23:8];
  endfunction

  // Expected sample for a LUT address, including amplitude scaling if built in
  function automatic logic [15:0] exp_sample(input logic [14:0] a);
`ifdef SINE_AMP_SCALE_EN
    longint d;
    longint p;
    d = longint'($signed(lut(a)));
    p = (d * longint'({48'd0, bus.amp})) >>> 15;
    return p[15:0];
`else
    return lut(a);
`endif
  endfunction

  // One-cycle LUT read latency
  always @(posedge clk) begin
    bus.data1 <= lut(bus.address1);
    bus.data2 <= lut(bus.address2);
    bus.data3 <= lut(bus.address3);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_fcw_idle(input logic [31:0] v);
    chk("ready_before_load", 64'(bus.fcw_ready), 64'd1);
    bus.fcw_in    = v;
    bus.fcw_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.fcw_valid = 1'b0;
    chk("ready_after_idle_load", 64'(bus.fcw_ready), 64'd1);
  endtask

  // Run for exactly n issues from IDLE and check addresses, valid strobe and samples
  task automatic burst(input logic [31:0] fcw, input int n);
    logic [14:0] a1 [0:63];
    logic [14:0] a2 [0:63];
    logic [14:0] a3 [0:63];
    logic [31:0] acc;
    logic [31:0] tmp;
    int          pulses;
    int          idx;
    int          ts;
    logic        expv;
    acc    = 32'd0;
    pulses = 0;
    bus.run = 1'b1;
    for (int t = 0; t <= n + L_LAT + 2; t++) begin
      @(posedge clk);
      #1;
      if (t == n - 1) bus.run = 1'b0;
      if (t >= 1 && t <= n) begin
        a1[t] = 15'(acc >> 17);
        tmp   = acc + PH120;
        a2[t] = 15'(tmp >> 17);
        tmp   = acc + PH240;
        a3[t] = 15'(tmp >> 17);
        acc   = acc + fcw;
      end
      if (t >= 1) begin
        idx = (t <= n) ? t : n;
        chk("address1", 64'(bus.address1), 64'(a1[idx]));
        chk("address2", 64'(bus.address2), 64'(a2[idx]));
        chk("address3", 64'(bus.address3), 64'(a3[idx]));
      end
      ts   = t - L_LAT;
      expv = (ts >= 1 && ts <= n);
      chk("sample_valid", 64'(bus.sample_valid), 64'(expv));
      if (bus.sample_valid === 1'b1) pulses++;
      if (expv) begin
        chk("sample1", 64'(bus.sample1), 64'(exp_sample(a1[ts])));
        chk("sample2", 64'(bus.sample2), 64'(exp_sample(a2[ts])));
        chk("sample3", 64'(bus.sample3), 64'(exp_sample(a3[ts])));
      end
    end
    chk("sample_pulse_count", 64'(pulses), 64'(n));
  endtask

  initial begin
    logic [31:0] f;
    int          n;
    rst           = 1'b0;
    bus.run       = 1'b0;
    bus.fcw_in    = 32'd0;
    bus.fcw_valid = 1'b0;
`ifdef SINE_AMP_SCALE_EN
    bus.amp       = 16'h8000;
`endif
    #2 rst = 1'b1;
    #1;
    // Reset state, before any clock edge
    chk("rst_address1", 64'(bus.address1), 64'd0);
    chk("rst_address2", 64'(bus.address2), 64'd0);
    chk("rst_address3", 64'(bus.address3), 64'd0);
    chk("rst_sample1", 64'(bus.sample1), 64'd0);
    chk("rst_sample2", 64'(bus.sample2), 64'd0);
    chk("rst_sample3", 64'(bus.sample3), 64'd0);
    chk("rst_sample_valid", 64'(bus.sample_valid), 64'd0);
    chk("rst_fcw_ready", 64'(bus.fcw_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Basic run: 10 issues at one address step per cycle, then restart at phase 0
    load_fcw_idle(32'h0002_0000);
    burst(32'h0002_0000, 10);
    idle(2);
    burst(32'h0002_0000, 3);
    idle(2);

    // Pending FCW applied at the phase wrap
    load_fcw_idle(32'h4000_0000);
    bus.run = 1'b1;
    idle(1);                                   // IDLE -> RUN
    idle(1);                                   // issue from acc 0
    chk("wrap_addr_acc0", 64'(bus.address1), 64'd0);
    bus.fcw_in    = 32'h0002_0000;
    bus.fcw_valid = 1'b1;
    idle(1);                                   // transfer, acc 0x4000_0000 issued
    chk("wrap_addr_acc40", 64'(bus.address1), 64'd8192);
    chk("wrap_ready_low1", 64'(bus.fcw_ready), 64'd0);
    bus.fcw_in = 32'h7FFF_FFFF;                // offered while not ready: must be ignored
    idle(1);
    chk("wrap_addr_acc80", 64'(bus.address1), 64'd16384);
    chk("wrap_ready_low2", 64'(bus.fcw_ready), 64'd0);
    idle(1);                                   // acc wraps to 0 on this edge
    chk("wrap_addr_accC0", 64'(bus.address1), 64'd24576);
    chk("wrap_ready_low3", 64'(bus.fcw_ready), 64'd0);
    bus.fcw_valid = 1'b0;
    idle(1);
    chk("wrap_addr_acc0b", 64'(bus.address1), 64'd0);
    chk("wrap_addr2_acc0b", 64'(bus.address2), 64'd10922);
    chk("wrap_ready_high", 64'(bus.fcw_ready), 64'd1);
    idle(1);
    chk("wrap_new_fcw_1", 64'(bus.address1), 64'd1);
    idle(1);
    chk("wrap_new_fcw_2", 64'(bus.address1), 64'd2);
    bus.run = 1'b0;
    idle(8);

    // Pending FCW still outstanding when IDLE is entered
    load_fcw_idle(32'd1);
    bus.run = 1'b1;
    idle(1);
    idle(1);
    bus.fcw_in    = 32'h0004_0000;
    bus.fcw_valid = 1'b1;
    bus.run       = 1'b0;
    idle(1);
    bus.fcw_valid = 1'b0;
    chk("idle_pend_ready_low", 64'(bus.fcw_ready), 64'd0);
    idle(8);
    chk("idle_pend_ready_high", 64'(bus.fcw_ready), 64'd1);
    burst(32'h0004_0000, 5);
    idle(2);

    // Randomized FCW / burst lengths
    for (int k = 0; k < 4; k++) begin
      f = $urandom;
      n = int'($urandom_range(1, 12));
`ifdef SINE_AMP_SCALE_EN
      if (k == 0)      bus.amp = 16'h4000;
      else if (k == 1) bus.amp = 16'h8000;
      else             bus.amp = 16'($urandom_range(0, 32768));
`endif
      load_fcw_idle(f);
      burst(f, n);
      idle(2);
    end

    // Reset asserted mid-RUN aborts immediately
    load_fcw_idle($urandom);
    bus.run = 1'b1;
    idle(5);
    rst     = 1'b1;
    bus.run = 1'b0;
    #1;
    chk("midrst_address1", 64'(bus.address1), 64'd0);
    chk("midrst_address2", 64'(bus.address2), 64'd0);
    chk("midrst_address3", 64'(bus.address3), 64'd0);
    chk("midrst_sample1", 64'(bus.sample1), 64'd0);
    chk("midrst_sample_valid", 64'(bus.sample_valid), 64'd0);
    chk("midrst_fcw_ready", 64'(bus.fcw_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk("midrst_no_stale_valid", 64'(bus.sample_valid), 64'd0);
    end
    chk("midrst_sample_hold", 64'(bus.sample2), 64'd0);

    // fcw_cur was cleared by reset: constant addresses, valid every cycle
    burst(32'd0, 5);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
